// File: rtl/expr_pkg.sv
// Shared encodings for the expression recognizer and evaluator stages:
// FSM states, character classes and the ASCII constants both stages key on.
package expr_pkg;

  typedef enum logic [2:0] {
    EXP  = 3'd0,
    ACC  = 3'd1,
    PEXP = 3'd2,
    PACC = 3'd3,
    ERR  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    DIG = 3'd0,
    OP  = 3'd1,
    LP  = 3'd2,
    RP  = 3'd3,
    OTH = 3'd4
  } cls_e;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_LP   = 8'h28;
  localparam logic [7:0] CH_RP   = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Character classifier shared by recognizer and evaluator so both stages
// agree on every byte; digit is the operand value and is zero for non-digits.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch_i,
  output cls_e       cls_o,
  output logic [3:0] digit_o
);

  logic [7:0] ofs;

  assign ofs = ch_i - CH_0;

  always_comb begin
    cls_o   = OTH;
    digit_o = 4'd0;
    if (ch_i >= CH_0 && ch_i <= CH_9) begin
      cls_o   = DIG;
      digit_o = ofs[3:0];
    end else if (ch_i == CH_PLUS || ch_i == CH_STAR) begin
      cls_o = OP;
    end else if (ch_i == CH_LP) begin
      cls_o = LP;
    end else if (ch_i == CH_RP) begin
      cls_o = RP;
    end
  end

endmodule

// File: rtl/expr_eval.sv
// Sum-of-products evaluator for the single-digit '+'/'*' expression stream with
// one level of parentheses. Define EXPR_OVF_EN to add the sticky ovf output.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         ok,
  output logic [W-1:0] value,
  output logic         err
`ifdef EXPR_OVF_EN
  ,
  output logic         ovf
`endif
);

  state_e       state_q, state_d;
  logic [W-1:0] sum_q, sum_d, prod_q, prod_d;
  logic [W-1:0] psum_q, psum_d, pprod_q, pprod_d;

  cls_e         cls;
  logic [3:0]   digit;
  logic [W-1:0] digit_w;
  logic [W-1:0] prod_dig, pprod_dig, sum_add, psum_add, prod_rp;

  expr_char_class u_cls (
    .ch_i    (in),
    .cls_o   (cls),
    .digit_o (digit)
  );

  assign digit_w = {{(W-4){1'b0}}, digit};

`ifdef EXPR_OVF_EN
  logic [W+3:0] pd_w, ppd_w;
  logic [W:0]   sum_w, psum_w;
  logic [2*W:0] rp_w;
  logic         ovf_set;
  logic         ovf_q;

  // Wide intermediates keep the bits that truncation would discard.
  assign pd_w     = {4'b0, prod_q} * {{W{1'b0}}, digit};
  assign ppd_w    = {4'b0, pprod_q} * {{W{1'b0}}, digit};
  assign sum_w    = {1'b0, sum_q} + {1'b0, prod_q};
  assign psum_w   = {1'b0, psum_q} + {1'b0, pprod_q};
  assign rp_w     = {{(W+1){1'b0}}, prod_q} * {{W{1'b0}}, psum_w};
  assign prod_dig  = pd_w[W-1:0];
  assign pprod_dig = ppd_w[W-1:0];
  assign sum_add   = sum_w[W-1:0];
  assign psum_add  = psum_w[W-1:0];
  assign prod_rp   = rp_w[W-1:0];

  always_comb begin
    ovf_set = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        EXP:  ovf_set = (cls == DIG) && (|pd_w[W+3:W]);
        ACC:  ovf_set = (in == CH_PLUS) && sum_w[W];
        PEXP: ovf_set = (cls == DIG) && (|ppd_w[W+3:W]);
        PACC: ovf_set = ((in == CH_PLUS) && psum_w[W]) ||
                        ((cls == RP) && (|rp_w[2*W:W]));
        default: ovf_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign prod_dig  = prod_q * digit_w;
  assign pprod_dig = pprod_q * digit_w;
  assign sum_add   = sum_q + prod_q;
  assign psum_add  = psum_q + pprod_q;
  assign prod_rp   = prod_q * psum_add;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    psum_d  = psum_q;
    pprod_d = pprod_q;
    if (in_valid) begin
      unique case (state_q)
        EXP: begin
          if (cls == DIG) begin
            prod_d  = prod_dig;
            state_d = ACC;
          end else if (cls == LP) begin
            psum_d  = '0;
            pprod_d = W'(1);
            state_d = PEXP;
          end else begin
            state_d = ERR;
          end
        end
        ACC: begin
          if (in == CH_PLUS) begin
            sum_d   = sum_add;
            prod_d  = W'(1);
            state_d = EXP;
          end else if (in == CH_STAR) begin
            state_d = EXP;
          end else begin
            state_d = ERR;
          end
        end
        PEXP: begin
          if (cls == DIG) begin
            pprod_d = pprod_dig;
            state_d = PACC;
          end else begin
            state_d = ERR;
          end
        end
        PACC: begin
          if (in == CH_PLUS) begin
            psum_d  = psum_add;
            pprod_d = W'(1);
            state_d = PEXP;
          end else if (in == CH_STAR) begin
            state_d = PEXP;
          end else if (cls == RP) begin
            prod_d  = prod_rp;
            state_d = ACC;
          end else begin
            state_d = ERR;
          end
        end
        default: state_d = ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= EXP;
      sum_q   <= '0;
      prod_q  <= W'(1);
      psum_q  <= '0;
      pprod_q <= W'(1);
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      psum_q  <= psum_d;
      pprod_q <= pprod_d;
    end
  end

  assign ok    = (state_q == ACC);
  assign err   = (state_q == ERR);
  assign value = ok ? (sum_q + prod_q) : '0;

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: each driven character queues its expected
// ok/value/err, and a monitor compares them one edge later.
module tb_expr_eval;

  logic        clk;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in;
  logic        ok;
  logic [15:0] value;
  logic        err;
`ifdef EXPR_OVF_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic        ok;
    logic [15:0] val;
    logic        err;
  } exp_t;

  exp_t  eq[$];
  string tq[$];
  exp_t  e;
  string t;
  int    checks;
  int    failures;

  expr_eval #(.W(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in),
    .ok       (ok),
    .value    (value),
    .err      (err)
`ifdef EXPR_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic eok,
                      input int evl, input logic eerr, input string tag);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    in       = c;
    x.ok  = eok;
    x.val = 16'(evl);
    x.err = eerr;
    eq.push_back(x);
    tq.push_back(tag);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (eq.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (eq.size() > 0) begin
      check("drain_timeout", 32'(eq.size()), 32'd0);
      eq.delete();
      tq.delete();
    end
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    check({tag, "_ok"},  32'(ok),    32'd0);
    check({tag, "_val"}, 32'(value), 32'd0);
    check({tag, "_err"}, 32'(err),   32'd0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      t = tq.pop_front();
      check({t, "_ok"},  32'(ok),    32'(e.ok));
      check({t, "_val"}, 32'(value), 32'(e.val));
      check({t, "_err"}, 32'(err),   32'(e.err));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ok",  32'(ok),    32'd0);
    check("rst_val", 32'(value), 32'd0);
    check("rst_err", 32'(err),   32'd0);
`ifdef EXPR_OVF_EN
    check("rst_ovf", 32'(ovf),   32'd0);
`endif
    clr = 1'b1;

    // 1+2*3
    step(1, "1", 1, 1, 0, "a1");
    step(1, "+", 0, 0, 0, "a2");
    step(1, "2", 1, 3, 0, "a3");
    step(1, "*", 0, 0, 0, "a4");
    step(1, "3", 1, 7, 0, "a5");
    drain();
    pulse_clr("clr_a");

    // (1+2)*3
    step(1, "(", 0, 0, 0, "b1");
    step(1, "1", 0, 0, 0, "b2");
    step(1, "+", 0, 0, 0, "b3");
    step(1, "2", 0, 0, 0, "b4");
    step(1, ")", 1, 3, 0, "b5");
    step(1, "*", 0, 0, 0, "b6");
    step(1, "3", 1, 9, 0, "b7");
    drain();
    pulse_clr("clr_b");

    // 2*(3+4)+5
    step(1, "2", 1, 2, 0, "c1");
    step(1, "*", 0, 0, 0, "c2");
    step(1, "(", 0, 0, 0, "c3");
    step(1, "3", 0, 0, 0, "c4");
    step(1, "+", 0, 0, 0, "c5");
    step(1, "4", 0, 0, 0, "c6");
    step(1, ")", 1, 14, 0, "c7");
    step(1, "+", 0, 0, 0, "c8");
    step(1, "5", 1, 19, 0, "c9");
    drain();
    pulse_clr("clr_c");

    // 1++ then sticky error, recovery by clr
    step(1, "1", 1, 1, 0, "d1");
    step(1, "+", 0, 0, 0, "d2");
    step(1, "+", 0, 0, 1, "d3");
    step(1, "5", 0, 0, 1, "d4");
    step(1, "(", 0, 0, 1, "d5");
    step(0, "7", 0, 0, 1, "d6");
    drain();
    pulse_clr("clr_d");
    step(1, "4", 1, 4, 0, "d7");
    drain();
    pulse_clr("clr_d2");

    // idle cycles with garbage hold state
    step(1, "3", 1, 3, 0, "e1");
    for (int i = 0; i < 5; i++)
      step(0, 8'(8'hA0 + i), 1, 3, 0, $sformatf("e_idle%0d", i));
    step(1, "*", 0, 0, 0, "e2");
    step(1, "4", 1, 12, 0, "e3");
    drain();

    // reset mid-expression
    pulse_clr("clr_e");
    step(1, "(", 0, 0, 0, "f1");
    step(1, "2", 0, 0, 0, "f2");
    step(1, "+", 0, 0, 0, "f3");
    drain();
    pulse_clr("clr_f");
    step(1, "8", 1, 8, 0, "f4");
    drain();
    pulse_clr("clr_f2");

    // digit zero and 16-bit wraparound: 9^6 = 531441 -> 7153
    step(1, "0", 1, 0, 0, "g1");
    step(1, "+", 0, 0, 0, "g2");
    step(1, "9", 1, 9, 0, "g3");
    step(1, "*", 0, 0, 0, "g4");
    step(1, "9", 1, 81, 0, "g5");
    step(1, "*", 0, 0, 0, "g6");
    step(1, "9", 1, 729, 0, "g7");
    step(1, "*", 0, 0, 0, "g8");
    step(1, "9", 1, 6561, 0, "g9");
    step(1, "*", 0, 0, 0, "g10");
    step(1, "9", 1, 59049, 0, "g11");
    drain();
`ifdef EXPR_OVF_EN
    check("ovf_before", 32'(ovf), 32'd0);
`endif
    step(1, "*", 0, 0, 0, "g12");
    step(1, "9", 1, 7153, 0, "g13");
    drain();
`ifdef EXPR_OVF_EN
    check("ovf_after", 32'(ovf), 32'd1);
`endif
    pulse_clr("clr_g");
`ifdef EXPR_OVF_EN
    check("ovf_clr", 32'(ovf), 32'd0);
`endif

    // grammar violations in each state
    step(1, "a", 0, 0, 1, "h1");
    drain();
    pulse_clr("clr_h1");
    step(1, 8'hFF, 0, 0, 1, "h2");
    drain();
    pulse_clr("clr_h2");
    step(1, ")", 0, 0, 1, "h3");
    drain();
    pulse_clr("clr_h3");
    step(1, "(", 0, 0, 0, "h4");
    step(1, "(", 0, 0, 1, "h5");
    drain();
    pulse_clr("clr_h5");
    step(1, "(", 0, 0, 0, "h6");
    step(1, "5", 0, 0, 0, "h7");
    step(1, "7", 0, 0, 1, "h8");
    drain();
    pulse_clr("clr_h8");
    step(1, "5", 1, 5, 0, "h9");
    step(1, "(", 0, 0, 1, "h10");
    drain();
    pulse_clr("clr_h10");

    // parens with inner product: 3+(2*4+1)*2 = 21
    step(1, "3", 1, 3, 0, "i1");
    step(1, "+", 0, 0, 0, "i2");
    step(1, "(", 0, 0, 0, "i3");
    step(1, "2", 0, 0, 0, "i4");
    step(1, "*", 0, 0, 0, "i5");
    step(1, "4", 0, 0, 0, "i6");
    step(1, "+", 0, 0, 0, "i7");
    step(1, "1", 0, 0, 0, "i8");
    step(1, ")", 1, 12, 0, "i9");
    step(1, "*", 0, 0, 0, "i10");
    step(1, "2", 1, 21, 0, "i11");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
